madd_iter_acc: RTL and testbench

- Parametrised, iterative multiply-add / multiply-accumulate unit: out = in0*in1 + addend, computed by shift-add over W cycles.
- The addend is either the in2 operand (MADD mode) or an internal accumulator (MAC mode).
- Latency-insensitive val/rdy interfaces on input and output.
- Used as a shared arithmetic resource in multi-cycle datapaths where a fully combinational 2W-bit multiplier is too costly.

---
 rtl/madd_pkg.sv | 13 +
 rtl/madd_iter_acc_if.sv | 24 ++
 rtl/madd_iter_acc_dpath.sv | 74 +++++++
 rtl/madd_iter_acc.sv | 76 +++++++
 tb/tb_madd_iter_acc.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/madd_pkg.sv
// Shared types and constants for the iterative multiply-add unit.
package madd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic MODE_MADD = 1'b0;
    localparam logic MODE_MAC  = 1'b1;

endpackage

// File: rtl/madd_iter_acc_if.sv
// Request/response val-rdy bundle of the iterative multiply-add unit.
interface madd_iter_acc_if #(
    parameter int W = 8
);
    logic             in_val;
    logic             in_rdy;
    logic             in_mode;
    logic [W-1:0]     in0;
    logic [W-1:0]     in1;
    logic [2*W-1:0]   in2;
    logic             out_val;
    logic             out_rdy;
    logic [2*W-1:0]   out;

    modport master (
        output in_val, in_mode, in0, in1, in2, out_rdy,
        input  in_rdy, out_val, out
    );

    modport slave (
        input  in_val, in_mode, in0, in1, in2, out_rdy,
        output in_rdy, out_val, out
    );
endinterface

// File: rtl/madd_iter_acc_dpath.sv
// Shift-add datapath: operand shifters, running partial sum, accumulator and step counter.
module madd_iter_acc_dpath
    import madd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             add_i,
    input  logic             commit_i,
    input  logic             mode_i,
    input  logic [W-1:0]     in0_i,
    input  logic [W-1:0]     in1_i,
    input  logic [2*W-1:0]   in2_i,
    output logic             is_last_o,
    output logic             b_lsb_o,
    output logic [2*W-1:0]   partial_o
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [2*W-1:0] a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] partial_q, partial_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        acc_d     = acc_q;
        count_d   = count_q;
        if (load_i) begin
            a_d       = {{W{1'b0}}, in0_i};
            b_d       = in1_i;
            partial_d = (mode_i == MODE_MAC) ? acc_q : in2_i;
            count_d   = '0;
        end else if (step_i) begin
            // Sum wraps modulo 2^(2W); the multiplicand walks left as the multiplier walks right.
            if (add_i) begin
                partial_d = partial_q + a_q;
            end
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            count_d = count_q + 1'b1;
        end
        if (commit_i) begin
            acc_d = partial_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
        end
    end

    assign is_last_o = (count_q == CW'(W - 1));
    assign b_lsb_o   = b_q[0];
    assign partial_o = partial_q;

endmodule

// File: rtl/madd_iter_acc.sv
// Iterative multiply-add / multiply-accumulate: out = in0*in1 + (in2 or acc) over W shift-add cycles.
module madd_iter_acc
    import madd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    madd_iter_acc_if.slave  bus
);
    state_t state_q, state_d;

    logic           load, step, commit;
    logic           isLast, bLsb;
    logic [2*W-1:0] partial;

    madd_iter_acc_dpath #(.W(W)) u_dpath (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .step_i    (step),
        .add_i     (step & bLsb),
        .commit_i  (commit),
        .mode_i    (bus.in_mode),
        .in0_i     (bus.in0),
        .in1_i     (bus.in1),
        .in2_i     (bus.in2),
        .is_last_o (isLast),
        .b_lsb_o   (bLsb),
        .partial_o (partial)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // in_rdy depends only on state, so out_rdy never reaches it combinationally.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        commit      = 1'b0;
        bus.in_rdy  = 1'b0;
        bus.out_val = 1'b0;
        bus.out     = '0;
        case (state_q)
            IDLE: begin
                bus.in_rdy = 1'b1;
                if (bus.in_val) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (isLast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_val = 1'b1;
                bus.out     = partial;
                if (bus.out_rdy) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_madd_iter_acc.sv
// Randomized self-checking bench for madd_iter_acc at W=8 and W=16 against an arithmetic model.
module tb_madd_iter_acc;
    import madd_pkg::*;

    logic clk;
    logic reset_n;

    int numCompared   = 0;
    int numMismatched = 0;

    logic [15:0] accModel8;
    logic [31:0] accModel16;

    madd_iter_acc_if #(.W(8))  bus8 ();
    madd_iter_acc_if #(.W(16)) bus16 ();

    madd_iter_acc #(.W(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    madd_iter_acc #(.W(16)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One W=8 transaction, with the consumer stalling for 'hold' cycles in DONE.
    task automatic applyStimulus(input logic mode, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] c, input int hold);
        logic [15:0] expected;
        int lat;
        expected = (mode == MODE_MAC ? accModel8 : c) + (16'(a) * 16'(b));
        checkOutput("idleInRdy", 64'(bus8.in_rdy), 64'(1));
        bus8.in_val  = 1'b1;
        bus8.in_mode = mode;
        bus8.in0     = a;
        bus8.in1     = b;
        bus8.in2     = c;
        @(posedge clk); #1;
        bus8.in_val  = 1'b0;
        bus8.in_mode = 1'($urandom);
        bus8.in0     = 8'($urandom);
        bus8.in1     = 8'($urandom);
        bus8.in2     = 16'($urandom);
        checkOutput("calcInRdy", 64'(bus8.in_rdy), 64'(0));
        lat = 0;
        while (!bus8.out_val && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency8", 64'(lat), 64'(8));
        checkOutput("result8", 64'(bus8.out), 64'(expected));
        for (int i = 0; i < hold; i++) begin
            bus8.in_val = 1'($urandom);
            bus8.in0    = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("holdVal", 64'(bus8.out_val), 64'(1));
            checkOutput("holdOut", 64'(bus8.out), 64'(expected));
            checkOutput("holdInRdy", 64'(bus8.in_rdy), 64'(0));
        end
        bus8.in_val  = 1'b0;
        bus8.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus8.out_rdy = 1'b0;
        accModel8    = expected;
        checkOutput("postVal", 64'(bus8.out_val), 64'(0));
        checkOutput("postInRdy", 64'(bus8.in_rdy), 64'(1));
        checkOutput("postOut", 64'(bus8.out), 64'(0));
    endtask

    task automatic applyStimulus16(input logic mode, input logic [15:0] a, input logic [15:0] b,
                                   input logic [31:0] c);
        logic [31:0] expected;
        int lat;
        expected = (mode == MODE_MAC ? accModel16 : c) + (32'(a) * 32'(b));
        bus16.in_val  = 1'b1;
        bus16.in_mode = mode;
        bus16.in0     = a;
        bus16.in1     = b;
        bus16.in2     = c;
        @(posedge clk); #1;
        bus16.in_val  = 1'b0;
        bus16.in0     = 16'($urandom);
        lat = 0;
        while (!bus16.out_val && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency16", 64'(lat), 64'(16));
        checkOutput("result16", 64'(bus16.out), 64'(expected));
        bus16.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus16.out_rdy = 1'b0;
        accModel16    = expected;
        checkOutput("post16InRdy", 64'(bus16.in_rdy), 64'(1));
    endtask

    initial begin
        reset_n = 1'b0;
        accModel8  = '0;
        accModel16 = '0;
        bus8.in_val = 1'b0;  bus8.in_mode = 1'b0;  bus8.in0 = '0;  bus8.in1 = '0;  bus8.in2 = '0;
        bus8.out_rdy = 1'b0;
        bus16.in_val = 1'b0; bus16.in_mode = 1'b0; bus16.in0 = '0; bus16.in1 = '0; bus16.in2 = '0;
        bus16.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInRdy", 64'(bus8.in_rdy), 64'(1));
        checkOutput("rstOutVal", 64'(bus8.out_val), 64'(0));
        checkOutput("rstOut", 64'(bus8.out), 64'(0));
        reset_n = 1'b1;

        applyStimulus(MODE_MADD, 8'd3, 8'd5, 16'd7, 0);
        applyStimulus(MODE_MADD, 8'd255, 8'd255, 16'hFFFF, 0);
        applyStimulus(MODE_MADD, 8'd2, 8'd3, 16'd0, 0);
        applyStimulus(MODE_MAC, 8'd4, 8'd5, 16'($urandom), 0);
        applyStimulus(MODE_MAC, 8'd1, 8'd1, 16'($urandom), 5);

        // Abort an in-flight operation with a one-edge reset; the accumulator must clear.
        bus8.in_val = 1'b1; bus8.in_mode = MODE_MADD; bus8.in0 = 8'd9; bus8.in1 = 8'd9; bus8.in2 = 16'd1;
        @(posedge clk); #1;
        bus8.in_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        accModel8  = '0;
        accModel16 = '0;
        checkOutput("midRstInRdy", 64'(bus8.in_rdy), 64'(1));
        checkOutput("midRstOutVal", 64'(bus8.out_val), 64'(0));
        checkOutput("midRstOut", 64'(bus8.out), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midRstQuiet", 64'(bus8.out_val), 64'(0));
        applyStimulus(MODE_MAC, 8'd2, 8'd2, 16'($urandom), 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        applyStimulus16(MODE_MADD, 16'hFFFF, 16'hFFFF, 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus16(1'($urandom), 16'($urandom), 16'($urandom), 32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
